// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out and a host writer,
// with double-buffered banks swapped at vsync start and a 2-cycle pixel pipeline.
module vga_fb_arbiter #(
    parameter int FB_W = 160,
    parameter int FB_H = 120,
    parameter int AW   = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          videoon,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic          wr_err,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          front_bank,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW:0]   ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic [11:0]   rgb,
    output logic          hsync_out,
    output logic          vsync_out
);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t state_q, state_d;
    logic slot, wr_fire, wr_ok, vs_fall, swap_now;
    logic [AW-1:0] disp_addr;
    logic slot1_q, von1_q, hs1_q, hs2_q, vs1_q, vs2_q, front_q, ack_q, err_q;
    logic [7:0] pix_q, pix;
    logic [11:0] rgb_q, rgb_d;

    assign slot      = videoon && x[1:0] == 2'd0;
    assign disp_addr = AW'(32'(y[9:2]) * FB_W + 32'(x[9:2]));
    assign wr_ok     = 32'(wr_addr) < FB_W * FB_H;
    assign wr_ready  = !slot;
    assign wr_fire   = wr_valid && !slot;
    // display owns every 4th active cycle; writes use the back bank as seen this cycle
    assign ram_en    = slot || (wr_fire && wr_ok);
    assign ram_we    = !slot && wr_fire && wr_ok;
    assign ram_addr  = slot ? {front_q, disp_addr} : {~front_q, wr_addr};
    assign ram_wdata = wr_data;
    assign vs_fall   = vs1_q && !vsync_in;
    assign swap_now  = state_q == PENDING && vs_fall;

    always_comb begin
        state_d = (state_q == IDLE) ? (swap_req ? PENDING : IDLE) : (vs_fall ? IDLE : PENDING);
        pix     = slot1_q ? ram_rdata : pix_q;
        rgb_d   = von1_q ? {pix[7:5], pix[7], pix[4:2], pix[4], pix[1:0], pix[1:0]} : 12'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            front_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            slot1_q <= 1'b0;
            von1_q  <= 1'b0;
            pix_q   <= 8'd0;
            rgb_q   <= 12'd0;
            hs1_q   <= 1'b1;
            hs2_q   <= 1'b1;
            vs1_q   <= 1'b1;
            vs2_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            front_q <= front_q ^ swap_now;
            ack_q   <= swap_now;
            err_q   <= wr_fire && !wr_ok;
            slot1_q <= slot;
            von1_q  <= videoon;
            pix_q   <= pix;
            rgb_q   <= rgb_d;
            hs1_q   <= hsync_in;
            hs2_q   <= hs1_q;
            vs1_q   <= vsync_in;
            vs2_q   <= vs1_q;
        end
    end

    assign front_bank = front_q;
    assign swap_ack   = ack_q;
    assign wr_err     = err_q;
    assign rgb        = rgb_q;
    assign hsync_out  = hs2_q;
    assign vsync_out  = vs2_q;
endmodule
